// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall, branch squash and memory-wait freeze
// for the five-stage pipeline.
// Ports: clk, rst (sync, active-low); D/E/M/W register ids and write enables in;
// fad/fbd forwarding selects, stall_f/stall_d, flush_d/flush_e, freeze out;
// stall_cnt/flush_cnt performance counters, built only with HAZARD_PERF_CNT_EN
// and tied to 0 otherwise.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] dst_e,
    input  logic              regwrite_e,
    input  logic              mem2reg_e,
    input  logic [REG_AW-1:0] dst_m,
    input  logic              regwrite_m,
    input  logic              mem_req_m,
    input  logic [REG_AW-1:0] dst_w,
    input  logic              regwrite_w,
    input  logic              branch_taken_e,
    output logic [1:0]        fad,
    output logic [1:0]        fbd,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          lu;
    logic          mem_wait;
    logic          act;
    assign fad = (regwrite_m && dst_m != '0 && dst_m == rs_e) ? 2'b10 :
                 (regwrite_w && dst_w != '0 && dst_w == rs_e) ? 2'b01 : 2'b00;
    assign fbd = (regwrite_m && dst_m != '0 && dst_m == rt_e) ? 2'b10 :
                 (regwrite_w && dst_w != '0 && dst_w == rt_e) ? 2'b01 : 2'b00;
    assign lu = mem2reg_e && regwrite_e && dst_e != '0 && (dst_e == rs_d || dst_e == rt_d);
    // The release cycle (WAIT with cnt==0) is unfrozen so the access leaves M.
    assign mem_wait = (MEM_LAT > 0) &&
                      ((state == RUN && mem_req_m) || (state == WAIT && cnt != '0));
    assign freeze  = rst && mem_wait;
    // Hazard controls act only out of reset and while the pipeline is not frozen.
    assign act     = rst && !mem_wait;
    assign flush_d = act && branch_taken_e;
    assign flush_e = act && (branch_taken_e || lu);
    assign stall_f = act && !branch_taken_e && lu;
    assign stall_d = stall_f;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (MEM_LAT > 0 && state == RUN && mem_req_m) begin
            state <= WAIT;
            cnt   <= CW'(MEM_LAT - 1);
        end else if (state == WAIT) begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            else state <= RUN;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || stall_f) && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_d && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a reference model.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, dst_e, dst_m, dst_w;
    logic regwrite_e, mem2reg_e, regwrite_m, mem_req_m, regwrite_w, branch_taken_e;
    logic [1:0] fad, fbd, fad0, fbd0;
    logic stall_f, stall_d, flush_d, flush_e, freeze;
    logic stall_f0, stall_d0, flush_d0, flush_e0, freeze0;
    logic [31:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;
    int n_tests = 0;
    int n_fail = 0;
    int occ = 0;
    int m_stall = 0;
    int m_flush = 0;
    logic [1:0] e_fad, e_fbd;
    logic e_lu, e_frz, e_sf, e_fd, e_fe;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .MEM_LAT(LAT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .dst_e(dst_e), .regwrite_e(regwrite_e), .mem2reg_e(mem2reg_e), .dst_m(dst_m),
        .regwrite_m(regwrite_m), .mem_req_m(mem_req_m), .dst_w(dst_w),
        .regwrite_w(regwrite_w), .branch_taken_e(branch_taken_e), .fad(fad), .fbd(fbd),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    hazard_ctrl #(.REG_AW(AW), .MEM_LAT(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .dst_e(dst_e), .regwrite_e(regwrite_e), .mem2reg_e(mem2reg_e), .dst_m(dst_m),
        .regwrite_m(regwrite_m), .mem_req_m(mem_req_m), .dst_w(dst_w),
        .regwrite_w(regwrite_w), .branch_taken_e(branch_taken_e), .fad(fad0), .fbd(fbd0),
        .stall_f(stall_f0), .stall_d(stall_d0), .flush_d(flush_d0), .flush_e(flush_e0),
        .freeze(freeze0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

    function automatic logic [1:0] fwd(input logic [AW-1:0] r);
        if (regwrite_m && dst_m != 0 && dst_m == r) return 2'b10;
        if (regwrite_w && dst_w != 0 && dst_w == r) return 2'b01;
        return 2'b00;
    endfunction

    // occ counts how many cycles the current memory access has already sat in M;
    // an access spends LAT frozen cycles there, then one free cycle.
    always_comb begin
        e_fad = fwd(rs_e);
        e_fbd = fwd(rt_e);
        e_lu  = mem2reg_e && regwrite_e && dst_e != 0 && (dst_e == rs_d || dst_e == rt_d);
        e_frz = rst && ((occ == 0 && mem_req_m) || (occ > 0 && occ < LAT));
        e_fd  = rst && !e_frz && branch_taken_e;
        e_fe  = rst && !e_frz && (branch_taken_e || e_lu);
        e_sf  = rst && !e_frz && !branch_taken_e && e_lu;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk("fad", 32'(fad), 32'(e_fad));
        chk("fbd", 32'(fbd), 32'(e_fbd));
        chk("stall_f", 32'(stall_f), 32'(e_sf));
        chk("stall_d", 32'(stall_d), 32'(e_sf));
        chk("flush_d", 32'(flush_d), 32'(e_fd));
        chk("flush_e", 32'(flush_e), 32'(e_fe));
        chk("freeze", 32'(freeze), 32'(e_frz));
        chk("freeze_lat0", 32'(freeze0), 32'(0));
        chk("stall_f_lat0", 32'(stall_f0), 32'(rst && !branch_taken_e && e_lu));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall));
        chk("flush_cnt", flush_cnt, 32'(m_flush));
`else
        chk("stall_cnt", stall_cnt, 32'(0));
        chk("flush_cnt", flush_cnt, 32'(0));
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst) begin
            occ = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e_frz || e_sf) m_stall++;
            if (e_fd) m_flush++;
            if (occ == 0) occ = mem_req_m ? 1 : 0;
            else occ = (occ < LAT) ? occ + 1 : 0;
        end
        #1;
    endtask

    task automatic clear();
        {rs_d, rt_d, rs_e, rt_e, dst_e, dst_m, dst_w} = '0;
        {regwrite_e, mem2reg_e, regwrite_m, mem_req_m, regwrite_w, branch_taken_e} = '0;
    endtask

    initial begin
        clear();
        rst = 1'b0;
        #1;
        sample(); adv();
        sample(); adv();
        chk("reset_freeze", 32'(freeze), 32'(0));
        rst = 1'b1;
        regwrite_m = 1; dst_m = 3; regwrite_w = 1; dst_w = 3; rs_e = 3; rt_e = 4;
        sample(); chk("fwd_m_wins", 32'(fad), 32'(2)); chk("fwd_fbd_none", 32'(fbd), 32'(0)); adv();
        regwrite_m = 0;
        sample(); chk("fwd_w", 32'(fad), 32'(1)); adv();
        dst_m = 0; dst_w = 0; rs_e = 0; regwrite_m = 1;
        sample(); chk("fwd_r0", 32'(fad), 32'(0)); adv();
        clear();
        mem2reg_e = 1; regwrite_e = 1; dst_e = 5; rt_d = 5;
        sample(); chk("lu_stall", 32'({stall_f, stall_d, flush_e}), 32'(7)); adv();
        clear();
        dst_w = 5; regwrite_w = 1; rt_e = 5;
        sample(); chk("lu_fwd_w", 32'(fbd), 32'(1)); chk("lu_one_cycle", 32'(stall_f), 32'(0)); adv();
        clear();
        mem2reg_e = 1; regwrite_e = 1; dst_e = 5; rs_d = 5; branch_taken_e = 1;
        sample(); chk("br_vs_lu", 32'({flush_d, flush_e, stall_f}), 32'(6)); adv();
        clear();
        mem_req_m = 1;
        for (int i = 0; i < 8; i++) begin
            sample(); chk("mem_wait", 32'(freeze), 32'((i % 4) != 3)); adv();
        end
        branch_taken_e = 1;
        for (int i = 0; i < 4; i++) begin
            sample(); chk("br_deferred", 32'(flush_d), 32'(i == 3)); adv();
        end
        clear();
        mem_req_m = 1;
        sample(); adv();
        rst = 1'b0;
        sample(); adv();
        rst = 1'b1; mem_req_m = 0;
        sample(); chk("reset_abort", 32'(freeze), 32'(0)); adv();
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
            rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
            dst_e = AW'($urandom_range(0, 3)); dst_m = AW'($urandom_range(0, 3));
            dst_w = AW'($urandom_range(0, 3));
            regwrite_e = 1'($urandom); mem2reg_e = 1'($urandom);
            regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
            mem_req_m = ($urandom_range(0, 3) == 0);
            branch_taken_e = ($urandom_range(0, 5) == 0);
            sample(); adv();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
